// File: rtl/qpu_exu_alu_wbck_pkg.sv
// qpu_exu_alu_wbck_pkg
//   Shared widths for the ALU write-back slice and the layout of one buffered
//   write-back entry: {rdtime, rdidx, wdat}, rdtime in the MSB.
package qpu_exu_alu_wbck_pkg;

    localparam int QPU_XLEN        = 32;
    localparam int QPU_TIME_WIDTH  = 32;
    localparam int QPU_RFIDX_WIDTH = 5;

    // Width of one packed {rdtime, rdidx, wdat} entry.
    function automatic int wbck_ent_w(input int xlen, input int rfidx_w);
        return 1 + rfidx_w + xlen;
    endfunction

endpackage

// File: rtl/qpu_gnrl_fifo.sv
// qpu_gnrl_fifo
//   Small in-order FIFO with registered occupancy and a snapshot of every
//   slot (data + valid) for associative lookups by the owner.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     push_valid/ready/data      write side; ready = not full (registered state)
//     pop_valid/ready, head_data read side; pop_valid = head slot occupied
//     count                      occupied entries
//     entries, entry_valid       per-slot storage and valid bits
module qpu_gnrl_fifo #(
    parameter int DW    = 38,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_valid,
    output logic                           push_ready,
    input  logic [DW-1:0]                  push_data,
    output logic                           pop_valid,
    input  logic                           pop_ready,
    output logic [DW-1:0]                  head_data,
    output logic [$clog2(DEPTH):0]         count,
    output logic [DEPTH-1:0][DW-1:0]       entries,
    output logic [DEPTH-1:0]               entry_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]             wptr, rptr;
    logic [AW:0]               cnt_q;
    logic [DEPTH-1:0][DW-1:0]  mem;
    logic [DEPTH-1:0]          vld;
    logic                      push, pop;

    // Ready depends on count only, so a pop in the full cycle does not
    // reopen the input until the following cycle.
    assign push_ready = (cnt_q != FULL);
    assign push       = push_valid && push_ready;
    assign pop_valid  = vld[rptr];
    assign pop        = pop_ready && pop_valid;
    assign head_data  = mem[rptr];

    assign count       = cnt_q;
    assign entries     = mem;
    assign entry_valid = vld;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    // wptr == rptr only when empty or full, so push and pop never touch
    // the same valid bit in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            mem   <= '0;
            vld   <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                vld[wptr] <= 1'b1;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/qpu_exu_alu_wbck.sv
// qpu_exu_alu_wbck
//   ALU write-back stage. Buffers ALU results in order and commits each one
//   to the classical register file (always ready) or the time register
//   (valid/ready). Provides a pending-classical-write lookup for dispatch.
//   Ports:
//     clk, rst_n                    clock, synchronous active-low reset
//     alu_wbck_i_*                  result handshake in {wdat, rdidx, rdtime}
//     rf_wbck_*                     register-file write (ena, rdidx, wdat)
//     time_wbck_*                   time-register write (valid, ready, wdat)
//     chk_rdidx / chk_hit           pending-write lookup
//     wbck_cnt                      buffered entry count
module qpu_exu_alu_wbck
    import qpu_exu_alu_wbck_pkg::*;
#(
    parameter int XLEN        = QPU_XLEN,
    parameter int TIME_WIDTH  = QPU_TIME_WIDTH,
    parameter int RFIDX_WIDTH = QPU_RFIDX_WIDTH,
    parameter int DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_wbck_i_valid,
    output logic                       alu_wbck_i_ready,
    input  logic [XLEN-1:0]            alu_wbck_i_wdat,
    input  logic [RFIDX_WIDTH-1:0]     alu_wbck_i_rdidx,
    input  logic                       alu_wbck_i_rdtime,
    output logic                       rf_wbck_ena,
    output logic [RFIDX_WIDTH-1:0]     rf_wbck_rdidx,
    output logic [XLEN-1:0]            rf_wbck_wdat,
    output logic                       time_wbck_valid,
    input  logic                       time_wbck_ready,
    output logic [TIME_WIDTH-1:0]      time_wbck_wdat,
    input  logic [RFIDX_WIDTH-1:0]     chk_rdidx,
    output logic                       chk_hit,
    output logic [$clog2(DEPTH):0]     wbck_cnt
);

    localparam int EW = wbck_ent_w(XLEN, RFIDX_WIDTH);

    logic [EW-1:0]             head;
    logic                      head_vld;
    logic                      head_rdtime;
    logic [RFIDX_WIDTH-1:0]    head_rdidx;
    logic [XLEN-1:0]           head_wdat;
    logic                      pop;
    logic [DEPTH-1:0][EW-1:0]  ents;
    logic [DEPTH-1:0]          ents_vld;

    qpu_gnrl_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid  (alu_wbck_i_valid),
        .push_ready  (alu_wbck_i_ready),
        .push_data   ({alu_wbck_i_rdtime, alu_wbck_i_rdidx, alu_wbck_i_wdat}),
        .pop_valid   (head_vld),
        .pop_ready   (pop),
        .head_data   (head),
        .count       (wbck_cnt),
        .entries     (ents),
        .entry_valid (ents_vld)
    );

    assign head_rdtime = head[EW-1];
    assign head_rdidx  = head[XLEN +: RFIDX_WIDTH];
    assign head_wdat   = head[XLEN-1:0];

    // Classical entries always retire (x0 is dropped silently); time
    // entries wait for the timer, stalling everything behind them.
    assign rf_wbck_ena     = head_vld && !head_rdtime && (head_rdidx != '0);
    assign rf_wbck_rdidx   = rf_wbck_ena ? head_rdidx : '0;
    assign rf_wbck_wdat    = rf_wbck_ena ? head_wdat  : '0;
    assign time_wbck_valid = head_vld && head_rdtime;
    assign time_wbck_wdat  = time_wbck_valid ? head_wdat[TIME_WIDTH-1:0] : '0;
    assign pop             = head_vld && (!head_rdtime || time_wbck_ready);

    // Only the tag fields matter for the lookup; fold the data bits away.
    logic unused_ents_wdat;
    always_comb begin
        unused_ents_wdat = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            unused_ents_wdat = unused_ents_wdat ^ (^ents[i][XLEN-1:0]);
    end

    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ents_vld[i] && !ents[i][EW-1]
                && (ents[i][XLEN +: RFIDX_WIDTH] == chk_rdidx)
                && (ents[i][XLEN +: RFIDX_WIDTH] != '0))
                chk_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_qpu_exu_alu_wbck.sv
module tb_qpu_exu_alu_wbck;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_wdat;
    logic [4:0]  in_rdidx;
    logic        in_rdtime;
    logic        rf_ena;
    logic [4:0]  rf_rdidx;
    logic [31:0] rf_wdat;
    logic        t_valid;
    logic        t_ready;
    logic [31:0] t_wdat;
    logic [4:0]  chk_rdidx;
    logic        chk_hit;
    logic [1:0]  cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qpu_exu_alu_wbck dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alu_wbck_i_valid  (in_valid),
        .alu_wbck_i_ready  (in_ready),
        .alu_wbck_i_wdat   (in_wdat),
        .alu_wbck_i_rdidx  (in_rdidx),
        .alu_wbck_i_rdtime (in_rdtime),
        .rf_wbck_ena       (rf_ena),
        .rf_wbck_rdidx     (rf_rdidx),
        .rf_wbck_wdat      (rf_wdat),
        .time_wbck_valid   (t_valid),
        .time_wbck_ready   (t_ready),
        .time_wbck_wdat    (t_wdat),
        .chk_rdidx         (chk_rdidx),
        .chk_hit           (chk_hit),
        .wbck_cnt          (cnt)
    );

    // One row = one clock cycle: inputs held through the cycle, outputs
    // expected during that cycle (before the closing edge).
    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] wdat;
        logic [4:0]  idx;
        logic        tm;
        logic        tr;
        logic [4:0]  chk;
        logic        e_rdy;
        logic        e_rfe;
        logic [4:0]  e_rfidx;
        logic [31:0] e_rfw;
        logic        e_tv;
        logic [31:0] e_tw;
        logic        e_hit;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [31:0] wdat,
                       input logic [4:0] idx, input logic tm, input logic tr,
                       input logic [4:0] chk, input logic e_rdy, input logic e_rfe,
                       input logic [4:0] e_rfidx, input logic [31:0] e_rfw,
                       input logic e_tv, input logic [31:0] e_tw,
                       input logic e_hit, input logic [1:0] e_cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.wdat = wdat; r.idx = idx; r.tm = tm; r.tr = tr;
        r.chk = chk; r.e_rdy = e_rdy; r.e_rfe = e_rfe; r.e_rfidx = e_rfidx;
        r.e_rfw = e_rfw; r.e_tv = e_tv; r.e_tw = e_tw; r.e_hit = e_hit;
        r.e_cnt = e_cnt;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic check_outputs(input int row, input vec_t r);
        check("ready",      row, 32'(in_ready), 32'(r.e_rdy));
        check("rf_ena",     row, 32'(rf_ena),   32'(r.e_rfe));
        check("rf_rdidx",   row, 32'(rf_rdidx), 32'(r.e_rfidx));
        check("rf_wdat",    row, rf_wdat,       r.e_rfw);
        check("time_valid", row, 32'(t_valid),  32'(r.e_tv));
        check("time_wdat",  row, t_wdat,        r.e_tw);
        check("chk_hit",    row, 32'(chk_hit),  32'(r.e_hit));
        check("cnt",        row, 32'(cnt),      32'(r.e_cnt));
    endtask

    initial begin
        //   rst v  wdat           idx tm tr chk | rdy rfe rfidx rfw     tv tw             hit cnt
        // reset state
        add(1, 0, 32'h0,          0, 0, 0, 0,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        // single classical write, one-cycle latency, hit until pop edge
        add(1, 1, 32'h1234,       5, 0, 0, 5,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        add(1, 0, 32'h0,          0, 0, 0, 5,   1,  1,  5,   32'h1234, 0, 32'h0,          1,  1);
        add(1, 0, 32'h0,          0, 0, 0, 5,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        // time write held 3 cycles, popped when ready
        add(1, 1, 32'hFFFF_0064,  0, 1, 0, 0,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        add(1, 0, 32'h0,          0, 0, 0, 0,   1,  0,  0,   32'h0,    1, 32'hFFFF_0064,  0,  1);
        add(1, 0, 32'h0,          0, 0, 0, 0,   1,  0,  0,   32'h0,    1, 32'hFFFF_0064,  0,  1);
        add(1, 0, 32'h0,          0, 0, 0, 0,   1,  0,  0,   32'h0,    1, 32'hFFFF_0064,  0,  1);
        add(1, 0, 32'h0,          0, 0, 1, 0,   1,  0,  0,   32'h0,    1, 32'hFFFF_0064,  0,  1);
        add(1, 0, 32'h0,          0, 0, 0, 0,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        // stalled time write blocks classical writes; full ignores same-cycle pop
        add(1, 1, 32'hAA,         0, 1, 0, 0,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        add(1, 1, 32'h77,         7, 0, 0, 7,   1,  0,  0,   32'h0,    1, 32'hAA,         0,  1);
        add(1, 1, 32'h33,         3, 0, 0, 7,   0,  0,  0,   32'h0,    1, 32'hAA,         1,  2);
        add(1, 0, 32'h0,          0, 0, 0, 8,   0,  0,  0,   32'h0,    1, 32'hAA,         0,  2);
        add(1, 1, 32'h33,         3, 0, 1, 7,   0,  0,  0,   32'h0,    1, 32'hAA,         1,  2);
        add(1, 1, 32'h33,         3, 0, 0, 7,   1,  1,  7,   32'h77,   0, 32'h0,          1,  1);
        add(1, 0, 32'h0,          0, 0, 0, 7,   1,  1,  3,   32'h33,   0, 32'h0,          0,  1);
        add(1, 0, 32'h0,          0, 0, 0, 0,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        // x0 destination is dropped
        add(1, 1, 32'hDEAD,       0, 0, 0, 0,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        add(1, 0, 32'h0,          0, 0, 0, 0,   1,  0,  0,   32'h0,    0, 32'h0,          0,  1);
        add(1, 0, 32'h0,          0, 0, 0, 0,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        // reset with two entries buffered discards them
        add(1, 1, 32'h55,         0, 1, 0, 9,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        add(1, 1, 32'h99,         9, 0, 0, 9,   1,  0,  0,   32'h0,    1, 32'h55,         0,  1);
        add(0, 0, 32'h0,          0, 0, 0, 9,   0,  0,  0,   32'h0,    1, 32'h55,         1,  2);
        add(1, 0, 32'h0,          0, 0, 1, 9,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);
        add(1, 0, 32'h0,          0, 0, 1, 9,   1,  0,  0,   32'h0,    0, 32'h0,          0,  0);

        rst_n = 1'b0; in_valid = 1'b0; in_wdat = '0; in_rdidx = '0;
        in_rdtime = 1'b0; t_ready = 1'b0; chk_rdidx = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n     = vecs[i].rst;
            in_valid  = vecs[i].v;
            in_wdat   = vecs[i].wdat;
            in_rdidx  = vecs[i].idx;
            in_rdtime = vecs[i].tm;
            t_ready   = vecs[i].tr;
            chk_rdidx = vecs[i].chk;
            #1;
            check_outputs(i, vecs[i]);
        end

        // Back-to-back classical stream: simultaneous push/pop every cycle,
        // pointers wrap several times, occupancy stays at one.
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            rst_n     = 1'b1;
            in_valid  = (k < 6);
            in_rdidx  = 5'(k + 1);
            in_wdat   = 32'(k + 1) * 32'h101;
            in_rdtime = 1'b0;
            t_ready   = 1'b0;
            chk_rdidx = 5'(k);
            #1;
            check("stream_ready", 100 + k, 32'(in_ready), 32'h1);
            check("stream_cnt",   100 + k, 32'(cnt), (k > 0) ? 32'h1 : 32'h0);
            check("stream_ena",   100 + k, 32'(rf_ena), (k > 0) ? 32'h1 : 32'h0);
            check("stream_rdidx", 100 + k, 32'(rf_rdidx), (k > 0) ? 32'(k) : 32'h0);
            check("stream_wdat",  100 + k, rf_wdat, (k > 0) ? 32'(k) * 32'h101 : 32'h0);
            check("stream_hit",   100 + k, 32'(chk_hit), (k > 0) ? 32'h1 : 32'h0);
        end

        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("stream_drain_cnt", 200, 32'(cnt), 32'h0);
        check("stream_drain_ena", 200, 32'(rf_ena), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qpu_exu_alu_wbck.md
Name: qpu_exu_alu_wbck

Overview:
- Write-back stage on the consuming side of the regular-ALU result handshake.
- Accepts ALU results and buffers them in a small in-order FIFO.
- Commits each result to either the classical register file or the time register.
- Exposes a pending-write lookup so dispatch can hold instructions that read a register with an uncommitted write.

Parameters:
- XLEN, 32, result data width (matches QPU_XLEN)
- TIME_WIDTH, 32, time-register width (matches QPU_TIME_WIDTH, must be <= XLEN)
- RFIDX_WIDTH, 5, classical register index width
- DEPTH, 2, FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alu_wbck_i_valid  in  1  ALU result valid
- alu_wbck_i_ready  out  1  result accepted when valid and ready are both high
- alu_wbck_i_wdat  in  XLEN  result data
- alu_wbck_i_rdidx  in  RFIDX_WIDTH  destination classical register
- alu_wbck_i_rdtime  in  1  1 = destination is the time register (QWAIT); 0 = classical register
- rf_wbck_ena  out  1  classical register-file write enable
- rf_wbck_rdidx  out  RFIDX_WIDTH  write index
- rf_wbck_wdat  out  XLEN  write data
- time_wbck_valid  out  1  time-register write request
- time_wbck_ready  in  1  timer accepts the write
- time_wbck_wdat  out  TIME_WIDTH  time write data
- chk_rdidx  in  RFIDX_WIDTH  dispatch lookup index
- chk_hit  out  1  a buffered classical write targets chk_rdidx
- wbck_cnt  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_n low at a clk edge):
  - read/write pointers and count go to 0; all entry valid bits clear.
  - rf_wbck_ena, time_wbck_valid, chk_hit and wbck_cnt go to 0; data outputs go to 0.
  - alu_wbck_i_ready goes to 1 in the first cycle after reset.
  - Reset mid-operation discards every buffered entry with no write.
- Input handshake:
  - alu_wbck_i_ready = (count != DEPTH), driven from registered state only; there is no combinational path from time_wbck_ready.
  - A push stores {wdat, rdidx, rdtime} at the write pointer; the pointer wraps modulo DEPTH.
- Latency: a result pushed at edge N is visible at the head, and its write is driven, in cycle N+1. There is no bypass from input to output.
- Head processing, combinational from the head entry:
  - Classical, rdidx != 0: rf_wbck_ena = 1, rdidx and wdat driven; the entry is popped at that edge unconditionally (the register file is always ready).
  - Classical, rdidx == 0: no write (x0 is discarded); the entry is popped at that edge.
  - Time: time_wbck_valid = 1 and time_wbck_wdat = wdat[TIME_WIDTH-1:0] (upper bits truncated); the entry is popped only when time_wbck_ready = 1. time_wbck_valid stays high with stable data until it is accepted.
- FIFO boundaries:
  - Empty: no write outputs asserted; a push proceeds normally.
  - Full: ready is low, even if a pop occurs in the same cycle; ready returns the cycle after the pop.
  - Simultaneous push and pop: count is unchanged; both pointers advance.
  - Ordering is strictly in-order. A stalled time write blocks younger classical writes.
- Lookup: chk_hit = OR over valid entries of (!rdtime && rdidx == chk_rdidx && rdidx != 0). The head entry counts until its pop edge.
- wbck_cnt: registered occupancy, updated each edge as +push −pop.

Decomposition:
- Shared package/defines: XLEN, TIME_WIDTH, RFIDX_WIDTH, and an entry field layout macro {rdtime, rdidx, wdat} with its width.
- One natural sub-module: qpu_gnrl_fifo, holding the pointers, count, storage and per-entry valid bits, with an entry-array output for the lookup logic.
- Top level holds the head decode, pop condition and lookup logic.

Test Plan:
- Reset then single push of classical rdidx=5, wdat=0x1234 -> next cycle rf_wbck_ena=1, rdidx=5, wdat=0x1234; wbck_cnt returns 0 after that edge.
- Push time entry wdat=0xFFFF_0064 with time_wbck_ready=0 for 3 cycles -> time_wbck_valid held 3 cycles with time_wbck_wdat=0xFFFF_0064 (TIME_WIDTH=32); pops on the cycle ready=1.
- With a time write stalled, push 2 classical entries -> the first is accepted, the second sees ready=0 (DEPTH=2 full); no rf write until the time entry pops; order is preserved.
- Push classical rdidx=0, wdat=0xDEAD -> no rf_wbck_ena; entry popped; chk_hit=0 for chk_rdidx=0.
- Buffered classical rdidx=7 during a time stall, chk_rdidx=7 -> chk_hit=1; chk_rdidx=8 -> 0; after the pop, chk_hit=0.
- rst_n low for one edge while 2 entries are buffered -> cnt=0, no writes afterward, ready=1.
